// File: rtl/motoro3_mos_driver_dt.sv
// Multi-phase half-bridge gate driver with per-phase dead-time insertion and fault latch.
// All state updates on the falling clock edge; gate outputs decode straight from state.
module motoro3_mos_driver_dt #(
  parameter int NPH = 3,
  parameter int DTW = 8
) (
  input  logic           clk,
  input  logic           nRst,
  input  logic           mosEnable,
  input  logic [NPH-1:0] pwm,
  input  logic [NPH-1:0] h1_L0,
  input  logic [NPH-1:0] forceLow,
  input  logic           brake,
  input  logic [DTW-1:0] deadTime,
  input  logic           fault,
  input  logic           faultClr,
  output logic [NPH-1:0] mosHp,
  output logic [NPH-1:0] mosLp,
  output logic [NPH-1:0] deadBusy,
  output logic           faultLatched
);

  typedef enum logic [1:0] {S_OFF, S_HIGH, S_LOW, S_DEAD} state_e;
  typedef enum logic [1:0] {REQ_NONE, REQ_H, REQ_L} req_e;

  state_e         state_q [NPH];
  state_e         state_d [NPH];
  logic [DTW-1:0] cnt_q   [NPH];
  logic [DTW-1:0] cnt_d   [NPH];
  req_e           req     [NPH];
  logic           fault_latched_q;
  logic           fault_latched_d;
  logic           kill;

  // A live fault wins over a simultaneous clear.
  always_comb begin
    fault_latched_d = fault_latched_q;
    if (fault) begin
      fault_latched_d = 1'b1;
    end else if (faultClr) begin
      fault_latched_d = 1'b0;
    end
  end

  assign kill = ~mosEnable | fault | fault_latched_q;

  always_comb begin
    for (int i = 0; i < NPH; i++) begin
      req[i] = REQ_NONE;
      if (forceLow[i] | brake) begin
        req[i] = REQ_L;
      end else if (pwm[i] & h1_L0[i]) begin
        req[i] = REQ_H;
      end else if (pwm[i] & ~h1_L0[i]) begin
        req[i] = REQ_L;
      end
    end
  end

  // Every path into conduction goes through DEAD, so both switches are off for
  // at least deadTime+1 cycles before either one turns on.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < NPH; i++) begin
      if (kill) begin
        state_d[i] = S_OFF;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          S_OFF: begin
            if (req[i] != REQ_NONE) begin
              state_d[i] = S_DEAD;
              cnt_d[i]   = deadTime;
            end
          end
          S_HIGH: begin
            if (req[i] != REQ_H) begin
              state_d[i] = S_DEAD;
              cnt_d[i]   = deadTime;
            end
          end
          S_LOW: begin
            if (req[i] != REQ_L) begin
              state_d[i] = S_DEAD;
              cnt_d[i]   = deadTime;
            end
          end
          S_DEAD: begin
            if (cnt_q[i] != '0) begin
              cnt_d[i] = cnt_q[i] - {{(DTW-1){1'b0}}, 1'b1};
            end else begin
              case (req[i])
                REQ_H:   state_d[i] = S_HIGH;
                REQ_L:   state_d[i] = S_LOW;
                default: state_d[i] = S_OFF;
              endcase
            end
          end
          default: begin
            state_d[i] = S_OFF;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      fault_latched_q <= 1'b0;
      for (int i = 0; i < NPH; i++) begin
        state_q[i] <= S_OFF;
        cnt_q[i]   <= '0;
      end
    end else begin
      fault_latched_q <= fault_latched_d;
      for (int i = 0; i < NPH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // One-hot state decode: high and low drive can never be asserted together.
  always_comb begin
    mosHp    = '0;
    mosLp    = '0;
    deadBusy = '0;
    for (int i = 0; i < NPH; i++) begin
      mosHp[i]    = (state_q[i] == S_HIGH);
      mosLp[i]    = (state_q[i] == S_LOW);
      deadBusy[i] = (state_q[i] == S_DEAD);
    end
  end

  assign faultLatched = fault_latched_q;

endmodule
